// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the pipelined register file.
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  function automatic int rf_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: walks every entry once after reset, then
// holds READY until the next reset.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_we_o,
  output logic                  busy_o
);

  localparam int DEPTH = rf_depth(ADDR_WIDTH);
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  rf_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= RF_READY;
            busy_q  <= 1'b0;
          end
        end
        RF_READY: begin
          state_q <= RF_READY;
        end
        default: begin
          state_q <= RF_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // No clear write while rst is held; the counter restarts anyway.
  assign clr_we_o   = (state_q == RF_CLEAR) && !rst;
  assign clr_addr_o = cnt_q[ADDR_WIDTH-1:0];
  assign busy_o     = busy_q;

endmodule

// File: rtl/reg_file_pipe.sv
// Two-read/one-write register file with registered outputs and a
// post-reset clear sweep. REGFILE_BYPASS_EN enables write-through.
module reg_file_pipe
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic                  busy
);

  localparam int DEPTH = rf_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  busy_w;
  logic                  rd_zero;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] a_d;
  logic [DATA_WIDTH-1:0] b_d;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  reg_file_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_addr_o(clr_addr),
    .clr_we_o  (clr_we),
    .busy_o    (busy_w)
  );

  assign rd_zero = (ZERO_REG != 0) && (rd == '0);
  assign wr_ok   = we && !busy_w && !rst && !rd_zero;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[rd] <= dataIn;
    end
  end

  always_comb begin
    a_d = mem_q[rs];
    b_d = mem_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rd == rs)) a_d = dataIn;
    if (wr_ok && (rd == rt)) b_d = dataIn;
`endif
    if ((ZERO_REG != 0) && (rs == '0)) a_d = '0;
    if ((ZERO_REG != 0) && (rt == '0)) b_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || busy_w) begin
      a_q <= '0;
      b_q <= '0;
    end else if (re) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign busy = busy_w;

endmodule

// File: tb/tb_reg_file_pipe.sv
// Directed bench for reg_file_pipe; second instance uses ZERO_REG=0.
module tb_reg_file_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] dataIn;
  logic        re;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] A, B, zA, zB;
  logic        busy, zbusy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .dataIn(dataIn),
    .re(re), .rs(rs), .rt(rt), .A(A), .B(B), .busy(busy)
  );

  reg_file_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .dataIn(dataIn),
    .re(re), .rs(rs), .rt(rt), .A(zA), .B(zB), .busy(zbusy)
  );

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP7  = 32'h1234_5678;
  localparam logic [31:0] BYP31 = 32'hA5A5_A5A5;
  localparam logic [31:0] BYP9  = 32'h0C0F_FEE0;
`else
  localparam logic [31:0] BYP7  = 32'h0000_0001;
  localparam logic [31:0] BYP31 = 32'h0000_0000;
  localparam logic [31:0] BYP9  = 32'h0000_0000;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] din;
    logic        re;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] za;
    logic [31:0] zb;
  } vec_t;

  localparam int NV = 14;
  vec_t v [NV];

  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;
  localparam logic [31:0] N7 = 32'h1234_5678;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; rd = 0; dataIn = 0; re = 0; rs = 0; rt = 0;
  endtask

  // Counts edges until busy drops, checking A/B stay zero meanwhile.
  task automatic clear_wait(output int n);
    n = 0;
    do begin
      step();
      n++;
      chk("gateA", A, 32'h0);
      chk("gateB", B, 32'h0);
    end while (busy && n < 100);
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL clr_timeout: busy still %b after %0d", busy, n);
    end
  endtask

  initial begin
    int n;
    v[0]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd0,  5'd31, 32'h0, 32'h0, 32'h0, 32'h0};
    v[1]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd4,  5'd1,  32'h0, 32'h0, 32'h0, 32'h0};
    v[2]  = '{1'b1, 5'd5,  DB,    1'b0, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0};
    v[3]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd5,  5'd5,  DB,    DB,    DB,    DB};
    v[4]  = '{1'b1, 5'd0,  FF,    1'b0, 5'd0,  5'd0,  DB,    DB,    DB,    DB};
    v[5]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd0,  5'd5,  32'h0, DB,    FF,    DB};
    v[6]  = '{1'b1, 5'd7,  32'h1, 1'b0, 5'd0,  5'd0,  32'h0, DB,    FF,    DB};
    v[7]  = '{1'b1, 5'd7,  N7,    1'b1, 5'd7,  5'd5,  BYP7,  DB,    BYP7,  DB};
    v[8]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd7,  5'd7,  N7,    N7,    N7,    N7};
    v[9]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd1,  5'd2,  N7,    N7,    N7,    N7};
    v[10] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd31, 5'd0,
              BYP31, 32'h0, BYP31, FF};
    v[11] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd31, 5'd5,
              32'hA5A5_A5A5, DB, 32'hA5A5_A5A5, DB};
    v[12] = '{1'b1, 5'd9,  32'h0C0F_FEE0, 1'b1, 5'd5, 5'd9,
              DB, BYP9, DB, BYP9};
    v[13] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd9,  5'd9,
              32'h0C0F_FEE0, 32'h0C0F_FEE0, 32'h0C0F_FEE0, 32'h0C0F_FEE0};

    idle();
    rst = 1;
    step();
    step();
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    chk("rst_zbusy", {31'h0, zbusy}, 32'h1);

    // Write and read attempts during the clear must be ignored.
    rst = 0;
    we = 1; rd = 5'd4; dataIn = 32'h55; re = 1; rs = 5'd4; rt = 5'd4;
    clear_wait(n);
    idle();
    chk("clr_len", 32'(n), 32'd32);
    chk("clr_zbusy", {31'h0, zbusy}, 32'h0);

    for (int i = 0; i < 32; i++) begin
      re = 1; rs = 5'(i); rt = 5'(31 - i);
      step();
      chk("clrA", A, 32'h0);
      chk("clrB", B, 32'h0);
    end
    idle();

    for (int i = 0; i < NV; i++) begin
      we = v[i].we; rd = v[i].rd; dataIn = v[i].din;
      re = v[i].re; rs = v[i].rs; rt = v[i].rt;
      step();
      chk($sformatf("v%0d_A", i), A, v[i].ea);
      chk($sformatf("v%0d_B", i), B, v[i].eb);
      chk($sformatf("v%0d_zA", i), zA, v[i].za);
      chk($sformatf("v%0d_zB", i), zB, v[i].zb);
    end
    idle();

    we = 1; rd = 5'd3; dataIn = 32'h77;
    step();
    idle();
    re = 1; rs = 5'd3; rt = 5'd3;
    step();
    chk("r3_pre", A, 32'h77);

    // Reset in READY with a concurrent write to r3.
    rst = 1; re = 0; we = 1; rd = 5'd3; dataIn = 32'hAA;
    step();
    chk("rr_busy", {31'h0, busy}, 32'h1);
    chk("rr_A", A, 32'h0);
    chk("rr_B", B, 32'h0);
    step();
    chk("rr_hold", {31'h0, busy}, 32'h1);
    rst = 0;
    idle();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mid_busy", {31'h0, busy}, 32'h1);
    end
    rst = 1;
    step();
    rst = 0;
    clear_wait(n);
    chk("clr2_len", 32'(n), 32'd32);

    re = 1; rs = 5'd3; rt = 5'd7;
    step();
    chk("r3_post", A, 32'h0);
    chk("r7_post", B, 32'h0);
    idle();
    step();
    chk("hold_A", A, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_pipe.md
REG_FILE_PIPE -- requirements
Module: reg_file_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of every register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1, SHALL, when 1, hardwire register 0 to zero.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable
- rd  in  ADDR_WIDTH  write address
- dataIn  in  DATA_WIDTH  write data
- re  in  1  read enable, both ports
- rs  in  ADDR_WIDTH  read address, port A
- rt  in  ADDR_WIDTH  read address, port B
- A  out  DATA_WIDTH  registered read data, port A
- B  out  DATA_WIDTH  registered read data, port B
- busy  out  1  high while the clear sequence runs

Function
REQ-005 Block SHALL have two FSM states: CLEAR and READY.
REQ-006 In CLEAR, a counter SHALL zero one entry per cycle, addresses 0 to DEPTH-1 in order.
REQ-007 The FSM SHALL go from CLEAR to READY on the edge that clears entry DEPTH-1. CLEAR therefore lasts exactly DEPTH cycles after rst falls.
REQ-008 busy SHALL be registered and SHALL be 1 exactly while state = CLEAR.
REQ-009 While busy = 1, we and re SHALL be ignored, and A and B SHALL hold 0.
REQ-010 In READY, we = 1 SHALL write dataIn to entry rd on the rising edge.
REQ-011 A write to rd = 0 SHALL be discarded when ZERO_REG = 1.
REQ-012 In READY, re = 1 SHALL load A <= entry[rs] and B <= entry[rt] on the rising edge (1-cycle latency).
REQ-013 When re = 0, A and B SHALL hold their previous values.
REQ-014 Reads of address 0 SHALL return 0 when ZERO_REG = 1.
REQ-015 rs = rt SHALL be legal and SHALL give A = B.
REQ-016 A simultaneous write and read of the same address is governed by REQ-023/REQ-024.
REQ-017 Arithmetic: the counter SHALL be ADDR_WIDTH+1 bits wide. No wrap SHALL occur inside CLEAR.

Reset
REQ-018 rst = 1 at a rising edge SHALL set state = CLEAR, counter = 0, A = 0, B = 0 and busy = 1.
REQ-019 rst asserted in READY SHALL restart the clear from entry 0 and SHALL discard any same-cycle write.
REQ-020 rst asserted mid-CLEAR SHALL restart the counter at 0.
REQ-021 While rst stays high, counter SHALL hold 0 and busy SHALL stay 1.
REQ-022 Storage contents SHALL be defined only after CLEAR completes.

Configuration
REQ-023 With macro REGFILE_BYPASS_EN defined: if we = 1, re = 1 and rd = rs (or rd = rt), and the write is not discarded, the matching output SHALL load dataIn (write-through forwarding).
REQ-024 Without REGFILE_BYPASS_EN: in the case of REQ-023, the output SHALL load the old stored value, and the new value SHALL be readable from the next cycle.

Structure
REQ-025 Package reg_file_pkg SHALL hold:
- the state typedef (RF_CLEAR, RF_READY)
- default DATA_WIDTH and ADDR_WIDTH constants
REQ-026 Sub-module reg_file_clear_seq SHALL contain the FSM, the counter and busy. It SHALL output the clear address and a clear-write strobe to the storage array.

Verification
REQ-027 Clear sequence: rst high 2 cycles, then low -> busy = 1 for exactly 32 cycles, then 0; reads of r0..r31 all return 0.
REQ-028 Write then read: write r5 = 0xDEADBEEF, next cycle re with rs = 5, rt = 5 -> A = B = 0xDEADBEEF one cycle later.
REQ-029 Zero register: write r0 = 0xFFFFFFFF, then read rs = 0 -> A = 0. Repeat with ZERO_REG = 0 -> A = 0xFFFFFFFF.
REQ-030 Same-cycle write and read: write r7 = 0x12345678 with re = 1 and rs = 7 (old value 0x1):
- REGFILE_BYPASS_EN defined -> A = 0x12345678
- undefined -> A = 0x1
REQ-031 Reset mid-clear and mid-operation:
- rst pulsed at clear cycle 10 -> busy lasts 32 cycles from the second rst release
- rst during a write of r3 = 0xAA -> r3 reads 0 after the clear
REQ-032 Busy gating and hold: we = 1, rd = 4, dataIn = 0x55 and re = 1 during CLEAR -> A = B = 0 and r4 reads 0 afterwards; re = 0 in READY -> A and B unchanged.
